seq_detect_sequencer: RTL and testbench
=======================================

Name: seq_detect_sequencer

Overview:
- Controller that feeds a serial bit-pattern detector (single input bit `x`, single result bit) from a parallel word stream.
- Accepts a word over a valid/ready handshake and pulses a detector restart.
- Shifts the word into the detector MSB-first, one bit per clock, then waits a fixed detector latency.
- Samples the detector result, returns it over a valid/ready result handshake and keeps a saturating count of matches.

Parameters:
- WORD_W, 4, bits per word shifted into the detector (>=1).
- DET_LAT, 2, cycles from the last shifted bit to a valid det_hit (>=1).
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  word available.
- in_data  in  WORD_W  word to test.
- in_ready  out  1  sequencer can accept a word.
- abort  in  1  synchronous cancel of the current operation.
- det_start  out  1  one-cycle restart pulse to the detector.
- det_en  out  1  det_x is valid this cycle.
- det_x  out  1  serial bit to the detector.
- det_hit  in  1  detector result, sampled once per word.
- res_valid  out  1  result available.
- res_match  out  1  sampled det_hit value.
- res_ready  in  1  consumer takes the result.
- match_cnt  out  CNT_W  count of words that produced a match.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, shift register and counters=0, det_start=det_en=det_x=0, res_valid=res_match=0, match_cnt=0, in_ready=1.
- FSM states (registered): IDLE, START, SHIFT, WAIT, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: capture in_data, go to START.
- START (1 cycle):
  - det_start=1; bit counter=0; go to SHIFT.
- SHIFT (exactly WORD_W cycles):
  - det_en=1; det_x=captured word MSB-first (word[WORD_W-1] in the first cycle).
  - After the WORD_W-th cycle go to WAIT.
- WAIT (exactly DET_LAT cycles):
  - det_en=0, det_x=0.
  - det_hit is sampled at the edge ending the last WAIT cycle into res_match; go to REPORT.
- REPORT:
  - res_valid=1; res_match is held stable until the handshake completes.
  - On res_valid&res_ready: go to IDLE.
  - match_cnt increments by 1 if res_match=1, saturating at 2^CNT_W-1; it changes in the same edge as the handshake.
- Latency, counting the acceptance edge as edge 0:
  - det_start high in cycle 1.
  - det_x bits in cycles 2..WORD_W+1.
  - res_valid first high in cycle WORD_W+DET_LAT+2.
  - Defaults give 8.
- in_ready is 0 in all states except IDLE; there is no word buffering.
  - REPORT->IDLE and a new acceptance cannot happen in the same cycle; IDLE lasts at least 1 cycle.
- abort=1 in START, SHIFT or WAIT:
  - Next state IDLE; no result is produced and match_cnt is unchanged.
  - det_en/det_x are 0 from the next cycle.
- abort in IDLE or REPORT:
  - Ignored. A pending result is never dropped.
- abort together with in_valid in IDLE: the word is accepted.
- det_hit is ignored outside the final WAIT cycle.
- rst_n deasserted mid-operation:
  - Immediate return to the reset values above.
  - A partially shifted word is lost; the detector receives no further det_en.
- Counter widths: the bit counter is $clog2(WORD_W+1) bits and the wait counter is $clog2(DET_LAT+1) bits. Neither wraps during normal operation.

Decomposition:
- Shared package seq_detect_pkg:
  - state encoding localparams (IDLE=0, START=1, SHIFT=2, WAIT=3, REPORT=4) and the 3-bit state width;
  - default WORD_W/DET_LAT constants shared with the detector's pattern length.
- One natural sub-module, seq_piso:
  - parallel-in/serial-out shift register with load, shift enable and MSB output;
  - parameterised by WORD_W, async active-low reset.
- The FSM, counters and handshake logic remain in the top module.

Test Plan:
- Defaults. Send in_data=4'b1001 with a detector model that asserts det_hit for 1001, res_ready=1 -> det_start in cycle 1; det_x=1,0,0,1 in cycles 2-5; res_valid in cycle 8 with res_match=1; match_cnt=1.
- Send 4'b1011 -> res_match=0, match_cnt unchanged. Hold res_ready=0 for 5 cycles -> res_valid, res_match and in_ready=0 stay stable; the result is taken on the first res_ready=1.
- Back-to-back: in_valid held high with 1001 then 1001 -> second acceptance at least 1 IDLE cycle after the first handshake; match_cnt=2.
- abort in the 3rd SHIFT cycle -> IDLE next cycle, no res_valid, match_cnt unchanged, det_en=0. A following word 1001 completes normally.
- CNT_W=2, five matching words -> match_cnt sequence 1,2,3,3,3.
- rst_n pulsed low for 1 cycle mid-WAIT -> all outputs at reset values asynchronously; in_ready=1 after release; no stale result.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared state encoding and default sizes for the detector sequencer
package seq_detect_pkg;

    localparam int STATE_W     = 3;
    localparam int WORD_W_DEF  = 4;
    localparam int DET_LAT_DEF = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SHIFT  = 3'd2,
        WAIT   = 3'd3,
        REPORT = 3'd4
    } state_t;

endpackage

// File: rtl/seq_piso.sv
// rtl/seq_piso.sv - parallel-in/serial-out shift register, MSB presented first
module seq_piso #(
    parameter int WORD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift_en,
    input  logic [WORD_W-1:0] data,
    output logic              msb
);

    logic [WORD_W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= data;
        end else if (shift_en) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[WORD_W-1];

endmodule

// File: rtl/seq_detect_sequencer.sv
// rtl/seq_detect_sequencer.sv - feeds words bit-serially into a pattern detector and reports hits
module seq_detect_sequencer
    import seq_detect_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int DET_LAT = DET_LAT_DEF,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              abort,
    output logic              det_start,
    output logic              det_en,
    output logic              det_x,
    input  logic              det_hit,
    output logic              res_valid,
    output logic              res_match,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              busy
);

    localparam int BIT_W  = $clog2(WORD_W + 1);
    localparam int WAIT_W = $clog2(DET_LAT + 1);

    state_t            state, state_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              last_bit, last_wait, cancel, piso_msb;

    assign last_bit  = (bit_cnt == BIT_W'(WORD_W - 1));
    assign last_wait = (wait_cnt == WAIT_W'(DET_LAT - 1));
    // abort only cancels in-flight work; IDLE and a pending REPORT are immune
    assign cancel    = abort && (state == START || state == SHIFT || state == WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = START;
            START:   state_nxt = cancel ? IDLE : SHIFT;
            SHIFT:   if (cancel) state_nxt = IDLE; else if (last_bit) state_nxt = WAIT;
            WAIT:    if (cancel) state_nxt = IDLE; else if (last_wait) state_nxt = REPORT;
            REPORT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            res_match <= 1'b0;
            match_cnt <= '0;
        end else begin
            bit_cnt  <= (state == SHIFT) ? bit_cnt + BIT_W'(1) : '0;
            wait_cnt <= (state == WAIT) ? wait_cnt + WAIT_W'(1) : '0;
            if (state == WAIT && last_wait && !cancel) begin
                res_match <= det_hit;
            end
            if (state == REPORT && res_ready && res_match && match_cnt != '1) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

    seq_piso #(.WORD_W(WORD_W)) u_piso (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == IDLE && in_valid),
        .shift_en (state == SHIFT),
        .data     (in_data),
        .msb      (piso_msb)
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign det_start = (state == START);
    assign det_en    = (state == SHIFT);
    assign det_x     = det_en && piso_msb;
    assign res_valid = (state == REPORT);

endmodule

// File: tb/tb_seq_detect_sequencer.sv
// tb/tb_seq_detect_sequencer.sv - directed bench with a 1001 detector model
module tb_seq_detect_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       abort = 1'b0;
    logic       res_ready = 1'b0;
    logic       det_hit;
    logic       in_ready, det_start, det_en, det_x, res_valid, res_match, busy;
    logic [7:0] match_cnt;
    logic       in_ready2, det_start2, det_en2, det_x2, res_valid2, res_match2, busy2;
    logic [1:0] match_cnt2;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int exp_cnt2 = 0;

    always #5 clk = ~clk;

    seq_detect_sequencer #(.WORD_W(4), .DET_LAT(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .abort(abort), .det_start(det_start), .det_en(det_en), .det_x(det_x), .det_hit(det_hit),
        .res_valid(res_valid), .res_match(res_match), .res_ready(res_ready),
        .match_cnt(match_cnt), .busy(busy)
    );

    seq_detect_sequencer #(.WORD_W(4), .DET_LAT(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .abort(abort), .det_start(det_start2), .det_en(det_en2), .det_x(det_x2), .det_hit(det_hit),
        .res_valid(res_valid2), .res_match(res_match2), .res_ready(res_ready),
        .match_cnt(match_cnt2), .busy(busy2)
    );

    // Detector model: recognises the last four bits 1001
    logic [3:0] det_sr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         det_sr <= 4'd0;
        else if (det_start) det_sr <= 4'd0;
        else if (det_en)    det_sr <= {det_sr[2:0], det_x};
    end
    assign det_hit = (det_sr == 4'b1001);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic count_hit(input bit m);
        if (m) begin
            if (exp_cnt < 255) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
    endtask

    task automatic run_word(input logic [3:0] d, input bit em, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_pre", int'(in_ready), 1);
        in_data  = d;
        in_valid = 1'b1;
        res_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("det_start_c1", int'(det_start), 1);
        check("in_ready_c1", int'(in_ready), 0);
        for (int b = 3; b >= 0; b--) begin
            @(negedge clk);
            check("det_en_shift", int'(det_en), 1);
            check("det_x_shift", int'(det_x), int'(d[b]));
        end
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            check("det_en_wait", int'(det_en), 0);
            check("res_valid_wait", int'(res_valid), 0);
        end
        @(negedge clk);
        check("res_valid_c8", int'(res_valid), 1);
        check("res_match", int'(res_match), int'(em));
        for (int h = 0; h < hold; h++) begin
            abort = 1'b1;
            @(negedge clk);
            check("hold_res_valid", int'(res_valid), 1);
            check("hold_res_match", int'(res_match), int'(em));
            check("hold_in_ready", int'(in_ready), 0);
        end
        abort = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        count_hit(em);
        check("res_valid_after", int'(res_valid), 0);
        check("in_ready_after", int'(in_ready), 1);
        check("match_cnt", int'(match_cnt), exp_cnt);
        check("match_cnt_sat2", int'(match_cnt2), exp_cnt2);
    endtask

    typedef struct {
        logic [3:0] data;
        bit         match;
        int         hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        bit seen;
        vecs[0] = '{4'b1001, 1'b1, 0};
        vecs[1] = '{4'b1011, 1'b0, 5};
        vecs[2] = '{4'b0000, 1'b0, 0};
        vecs[3] = '{4'b1111, 1'b0, 2};
        vecs[4] = '{4'b1001, 1'b1, 3};
        vecs[5] = '{4'b0110, 1'b0, 0};

        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_det_start", int'(det_start), 0);
        check("rst_det_en", int'(det_en), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_match_cnt", int'(match_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Saturation on the 2-bit counter: expect 1,2,3,3,3
        for (int i = 0; i < 5; i++) run_word(4'b1001, 1'b1, 0);
        check("sat_final_cnt2", int'(match_cnt2), 3);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_cnt2 = 0;
        check("rst2_match_cnt", int'(match_cnt), 0);
        check("rst2_match_cnt2", int'(match_cnt2), 0);
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_word(vecs[i].data, vecs[i].match, vecs[i].hold);

        // Back-to-back with in_valid held high
        in_data = 4'b1001;
        in_valid = 1'b1;
        res_ready = 1'b1;
        n = 0;
        while (!res_valid && n < 30) begin @(negedge clk); n++; end
        check("b2b_res_valid1", int'(res_valid), 1);
        check("b2b_res_match1", int'(res_match), 1);
        @(negedge clk);
        count_hit(1'b1);
        check("b2b_idle_in_ready", int'(in_ready), 1);
        check("b2b_idle_det_start", int'(det_start), 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_second_start", int'(det_start), 1);
        n = 0;
        while (!res_valid && n < 30) begin @(negedge clk); n++; end
        check("b2b_res_valid2", int'(res_valid), 1);
        @(negedge clk);
        res_ready = 1'b0;
        count_hit(1'b1);
        check("b2b_match_cnt", int'(match_cnt), exp_cnt);

        // Abort in the third SHIFT cycle
        in_data = 4'b1001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_pre_det_en", int'(det_en), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_det_en", int'(det_en), 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_result", int'(seen), 0);
        check("abort_match_cnt", int'(match_cnt), exp_cnt);
        run_word(4'b1001, 1'b1, 0);

        // Reset pulse during WAIT
        in_data = 4'b1001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("midwait_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        exp_cnt2 = 0;
        check("async_in_ready", int'(in_ready), 1);
        check("async_busy", int'(busy), 0);
        check("async_det_en", int'(det_en), 0);
        check("async_res_valid", int'(res_valid), 0);
        check("async_res_match", int'(res_match), 0);
        check("async_match_cnt", int'(match_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid || det_en) seen = 1'b1;
        end
        check("post_rst_no_result", int'(seen), 0);
        check("post_rst_in_ready", int'(in_ready), 1);
        run_word(4'b1001, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
